// File: rtl/reg_access_sequencer.sv
// Sequences the register-file bus strobes (select, out, in, Y load, ALU start)
// for one instruction at a time, with ALU timeout, field checking and abort.
module reg_access_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [1:0]  op_class,
  input  logic        alu_ready,
  input  logic        abort,
  output logic [3:0]  reg_sel,
  output logic        r_out,
  output logic        r_in,
  output logic        y_load,
  output logic        alu_go,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, WAIT_ALU, WR_A, DONE} state_t;

  localparam logic [3:0] NO_REG = 4'b1111;

  state_t     state, state_nx;
  logic [3:0] ra_q, rb_q, rc_q;
  logic [1:0] cls_q;
  logic [3:0] wcnt;
  logic       err_q, err_nx;
  logic       bad_field;
  logic       unused_ir;

  // Only the three register fields matter to the sequencer.
  assign unused_ir = ^{ir[31:27], ir[14:0]};

  // A field is only checked when the requested class actually uses it.
  always_comb begin
    bad_field = (ir[26:23] == NO_REG);
    if (op_class[1] == 1'b0 && ir[22:19] == NO_REG) bad_field = 1'b1;
    if (op_class == 2'b00 && ir[18:15] == NO_REG)   bad_field = 1'b1;
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          if (bad_field) begin
            state_nx = DONE;
            err_nx   = 1'b1;
          end else begin
            case (op_class)
              2'b10:   state_nx = RD_A;
              2'b11:   state_nx = WR_A;
              default: state_nx = RD_B;
            endcase
          end
        end
      RD_A:     state_nx = DONE;
      RD_B:     state_nx = (cls_q == 2'b00) ? RD_C : WAIT_ALU;
      RD_C:     state_nx = WAIT_ALU;
      WAIT_ALU:
        if (alu_ready) state_nx = WR_A;
        else if (wcnt == 4'hF) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      WR_A:     state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    // Abort wins over ALU completion and timeout.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      cls_q <= '0;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      // Counter only advances while staying in WAIT_ALU, so it is zero on entry.
      wcnt  <= (state == WAIT_ALU && state_nx == WAIT_ALU) ? wcnt + 4'd1 : 4'd0;
      if (state == IDLE && start) begin
        ra_q  <= ir[26:23];
        rb_q  <= ir[22:19];
        rc_q  <= ir[18:15];
        cls_q <= op_class;
      end
    end
  end

  // An aborting cycle drives no strobes and no completion.
  always_comb begin
    reg_sel = NO_REG;
    r_out   = 1'b0;
    r_in    = 1'b0;
    y_load  = 1'b0;
    alu_go  = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    busy    = (state != IDLE);
    if (!abort) begin
      case (state)
        RD_A: begin
          reg_sel = ra_q;
          r_out   = 1'b1;
        end
        RD_B: begin
          reg_sel = rb_q;
          r_out   = 1'b1;
          y_load  = (cls_q == 2'b00);
          alu_go  = (cls_q == 2'b01);
        end
        RD_C: begin
          reg_sel = rc_q;
          r_out   = 1'b1;
          alu_go  = 1'b1;
        end
        WR_A: begin
          reg_sel = ra_q;
          r_in    = 1'b1;
        end
        DONE: begin
          done  = 1'b1;
          error = err_q;
        end
        default: ;
      endcase
    end
  end
endmodule
